bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-005 SHALL have port din_valid, input, 1 bit: din is valid this cycle.
REQ-006 SHALL have port din_ready, output, 1 bit: block accepts din this cycle.
REQ-007 SHALL have port sout, output, 1 bit: serial bit stream, MSB first; drives the ip input of the downstream sequence detector.
REQ-008 SHALL have port sout_valid, output, 1 bit: sout carries a frame bit this cycle.
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the final serial bit of a frame.

Function
REQ-010 SHALL register all outputs.
REQ-011 SHALL implement states IDLE and SHIFT, plus PARITY when PARITY_EN is defined.
REQ-012 SHALL accept a word when din_valid=1 and din_ready=1 at a rising edge; this is a handshake.
REQ-013 SHALL ignore din_valid when din_ready=0; din is not latched and no error is raised.
REQ-014 SHALL drive din_ready=1 in IDLE and during the final serial bit cycle of a frame, and 0 otherwise.
REQ-015 SHALL transition IDLE->SHIFT on a handshake, latching din into the shift register.
REQ-016 SHALL drive sout=din[WIDTH-1] with sout_valid=1 in the cycle after the handshake (latency 1).
REQ-017 SHALL shift left once per cycle in SHIFT, presenting bits WIDTH-1 down to 0 over exactly WIDTH cycles.
REQ-018 SHALL use a bit counter of width clog2(WIDTH); it loads WIDTH-1 on handshake, decrements each SHIFT cycle, and does not wrap.
REQ-019 SHALL, after bit 0, go to PARITY if enabled, else to IDLE.
REQ-020 SHALL, on a handshake during the final bit cycle, go directly to SHIFT with the new MSB on sout next cycle (zero-bubble streaming).
REQ-021 SHALL pulse frame_done=1 exactly during the last bit cycle (bit 0, or the parity bit if enabled).
REQ-022 SHALL hold sout=0 and sout_valid=0 in IDLE, so the detector sees 0s between frames.

Reset
REQ-023 SHALL, while reset=0, force state=IDLE, shift register=0, bit counter=0, sout=0, sout_valid=0, frame_done=0, and din_ready=0.
REQ-024 SHALL drive din_ready=1 from the first rising edge after reset deasserts.
REQ-025 SHALL discard any frame in progress when reset is asserted mid-frame; no frame_done is produced and no partial bits resume after release.

Configuration
REQ-026 SHALL use the macro BIT_SERIALIZER_PARITY_EN.
REQ-027 SHALL, when BIT_SERIALIZER_PARITY_EN is defined, append one even-parity bit (XOR of the latched word) after bit 0, with sout_valid=1; frame length is WIDTH+1 cycles.
REQ-028 SHALL, when BIT_SERIALIZER_PARITY_EN is undefined, omit the PARITY state entirely; frame length is WIDTH cycles.

Verification
REQ-029 Reset with reset=0 for 10 ns, then release -> all outputs 0 during reset; din_ready=1 on the first edge after release.
REQ-030 WIDTH=8, din=8'h99 with a single valid -> sout 1,0,0,1,1,0,0,1 on consecutive cycles; sout_valid=1 for 8 cycles; frame_done only on the 8th; a detector driven by sout reports 1001 twice.
REQ-031 Back-to-back: 8'h90 then 8'h09, second valid held during the last bit -> 16 contiguous valid bits 1001000000001001 with no gap cycle; two frame_done pulses 8 cycles apart.
REQ-032 Busy: din_valid=1 with din=8'hFF pulsed on bit 3 of a frame -> ignored; the frame completes unchanged and sout returns to 0 afterwards.
REQ-033 Mid-frame reset: reset=0 after bit 4 of 8'hA5 -> sout=0, sout_valid=0 immediately (asynchronous); no frame_done; IDLE after release.
REQ-034 With BIT_SERIALIZER_PARITY_EN defined, din=8'h07 -> sout 0,0,0,0,0,1,1,1 then parity 1; frame_done on the 9th bit; din=8'h03 -> parity 0.

Source files
------------

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//
// Purpose:
//   Converts a WIDTH-bit parallel word into an MSB-first serial stream with a
//   valid/ready handshake on the parallel side. A new word can be accepted
//   during the last serial bit of the current frame, so consecutive frames
//   stream with no idle gap between them. Between frames the serial output
//   is held at 0 so a downstream sequence detector only ever sees zeros.
//
// Configuration:
//   BIT_SERIALIZER_PARITY_EN - when defined, one even-parity bit (XOR of the
//   latched word) follows bit 0 and a frame lasts WIDTH+1 cycles. When it is
//   undefined there is no parity state and a frame lasts WIDTH cycles.
//
// Parameters:
//   WIDTH       parallel word width in bits (2..32)
//
// Ports:
//   clk         in   single clock, rising-edge active
//   reset       in   asynchronous reset, active low (0 = in reset)
//   din         in   parallel word to serialize
//   din_valid   in   din is valid this cycle
//   din_ready   out  word is accepted this cycle if din_valid is also high
//   sout        out  serial bit, MSB first
//   sout_valid  out  sout carries a frame bit this cycle
//   frame_done  out  one-cycle pulse on the final bit of a frame
// ---------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_done
);

    // Counter only has to hold WIDTH-1, so clog2(WIDTH) bits are enough.
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic               parity_bit;
    logic               parity_next;
`endif

    logic               din_ready_next;
    logic               sout_next;
    logic               sout_valid_next;
    logic               frame_done_next;
    logic               handshake;

    // din_ready is a register that is only ever high in IDLE or in the last
    // bit of a frame, so a handshake is by construction only possible there.
    assign handshake = din_valid & din_ready;

    // State register: FSM state, datapath, and the registered outputs.
    // Reset clears everything, which also drops any frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_bit <= 1'b0;
`endif
            din_ready  <= 1'b0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            cnt        <= cnt_next;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_bit <= parity_next;
`endif
            din_ready  <= din_ready_next;
            sout       <= sout_next;
            sout_valid <= sout_valid_next;
            frame_done <= frame_done_next;
        end
    end

    // Next-state logic. A handshake always (re)starts a frame, whether from
    // IDLE or from the final bit of the previous frame; that is what gives
    // zero-bubble streaming. Otherwise SHIFT walks the counter down to 0 and
    // then leaves for PARITY (if built in) or IDLE.
    always_comb begin
        state_next  = state;
        shreg_next  = shreg;
        cnt_next    = cnt;
`ifdef BIT_SERIALIZER_PARITY_EN
        parity_next = parity_bit;
`endif
        if (handshake) begin
            state_next  = SHIFT;
            shreg_next  = din;
            cnt_next    = CNT_LOAD;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_next = ^din;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        shreg_next = {shreg[WIDTH-2:0], 1'b0};
                        cnt_next   = cnt - CNT_ONE;
                    end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = IDLE;
`endif
                    end
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                PARITY: begin
                    state_next = IDLE;
                end
`endif
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output logic. Outputs are registered, so their next values are derived
    // from the next state: the MSB of the next shift register is what goes on
    // the wire, and the "last bit" flags are raised when the next cycle is the
    // final one of the frame.
    always_comb begin
        din_ready_next  = 1'b0;
        sout_next       = 1'b0;
        sout_valid_next = 1'b0;
        frame_done_next = 1'b0;
        case (state_next)
            IDLE: begin
                din_ready_next = 1'b1;
            end
            SHIFT: begin
                sout_next       = shreg_next[WIDTH-1];
                sout_valid_next = 1'b1;
`ifndef BIT_SERIALIZER_PARITY_EN
                if (cnt_next == '0) begin
                    frame_done_next = 1'b1;
                    din_ready_next  = 1'b1;
                end
`endif
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                sout_next       = parity_next;
                sout_valid_next = 1'b1;
                frame_done_next = 1'b1;
                din_ready_next  = 1'b1;
            end
`endif
            default: begin
                din_ready_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer
//
// Purpose:
//   Self-checking bench for bit_serializer (WIDTH=8). Expected serial bits
//   and frame_done flags are pushed to queues when a word is driven and
//   popped as the DUT presents valid bits. Honours BIT_SERIALIZER_PARITY_EN
//   the same way the design does.
// ---------------------------------------------------------------------------
module tb_bit_serializer;

    localparam int WIDTH = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_done;

    int   checks = 0;
    int   errors = 0;
    logic bit_q[$];
    logic done_q[$];

    bit_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Push the expected serial bits and frame_done flags of one word.
    task automatic push_frame(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            bit_q.push_back(w[i]);
`ifdef BIT_SERIALIZER_PARITY_EN
            done_q.push_back(1'b0);
`else
            done_q.push_back(i == 0);
`endif
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        bit_q.push_back(^w);
        done_q.push_back(1'b1);
`endif
    endtask

    // Bounded wait (at negedges) for din_ready.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (din_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({din_ready, sout, sout_valid, frame_done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b expected 0000",
                     {din_ready, sout, sout_valid, frame_done});
        end
        reset = 1'b1;
        #1;
        checks++;
        if (din_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_before_edge got %b expected 0", din_ready);
        end
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1 || sout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_after_release got ready=%b valid=%b expected 1/0",
                     din_ready, sout_valid);
        end
    endtask

    task automatic test_single();
        bit         ok;
        logic       eb, ed;
        logic [3:0] win;
        int         hits;
        win  = '0;
        hits = 0;
        wait_ready(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL single_ready_timeout got 0 expected 1");
            return;
        end
        din = 8'h99; din_valid = 1'b1;
        push_frame(8'h99);
        @(negedge clk);
        din_valid = 1'b0; din = '0;
        for (int c = 0; c < FL; c++) begin
            eb = bit_q.pop_front();
            ed = done_q.pop_front();
            checks++;
            if (sout_valid !== 1'b1 || sout !== eb || frame_done !== ed) begin
                errors++;
                $display("[TB] FAIL single_bit%0d got v=%b s=%b d=%b expected v=1 s=%b d=%b",
                         c, sout_valid, sout, frame_done, eb, ed);
            end
            win = {win[2:0], sout};
            if (win == 4'b1001) hits++;
            @(negedge clk);
        end
        checks++;
        if (hits != 2) begin
            errors++;
            $display("[TB] FAIL single_1001_hits got %0d expected 2", hits);
        end
        checks++;
        if (sout !== 1'b0 || sout_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle got s=%b v=%b d=%b expected 0/0/0",
                     sout, sout_valid, frame_done);
        end
    endtask

    task automatic test_back_to_back();
        bit   ok;
        logic eb, ed, er;
        int   d1, d2;
        d1 = -1;
        d2 = -1;
        wait_ready(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL b2b_ready_timeout got 0 expected 1");
            return;
        end
        din = 8'h90; din_valid = 1'b1;
        push_frame(8'h90);
        push_frame(8'h09);
        @(negedge clk);
        din = 8'h09;
        for (int c = 0; c < 2 * FL; c++) begin
            if (c == FL) begin
                din_valid = 1'b0;
                din = '0;
            end
            eb = bit_q.pop_front();
            ed = done_q.pop_front();
            er = (c == FL - 1) || (c == 2 * FL - 1);
            checks++;
            if (sout_valid !== 1'b1 || sout !== eb || frame_done !== ed || din_ready !== er) begin
                errors++;
                $display("[TB] FAIL b2b_bit%0d got v=%b s=%b d=%b r=%b expected v=1 s=%b d=%b r=%b",
                         c, sout_valid, sout, frame_done, din_ready, eb, ed, er);
            end
            if (frame_done === 1'b1) begin
                if (d1 < 0) d1 = c;
                else d2 = c;
            end
            @(negedge clk);
        end
        checks++;
        if (d1 < 0 || d2 < 0 || (d2 - d1) != FL) begin
            errors++;
            $display("[TB] FAIL b2b_done_spacing got %0d,%0d expected spacing %0d", d1, d2, FL);
        end
        checks++;
        if (sout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle got v=%b expected 0", sout_valid);
        end
    endtask

    task automatic test_busy();
        bit   ok;
        logic eb, ed;
        wait_ready(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL busy_ready_timeout got 0 expected 1");
            return;
        end
        din = 8'hA3; din_valid = 1'b1;
        push_frame(8'hA3);
        @(negedge clk);
        din_valid = 1'b0; din = '0;
        for (int c = 0; c < FL; c++) begin
            eb = bit_q.pop_front();
            ed = done_q.pop_front();
            checks++;
            if (sout_valid !== 1'b1 || sout !== eb || frame_done !== ed) begin
                errors++;
                $display("[TB] FAIL busy_bit%0d got v=%b s=%b d=%b expected v=1 s=%b d=%b",
                         c, sout_valid, sout, frame_done, eb, ed);
            end
            if (c == 3) begin
                din = 8'hFF; din_valid = 1'b1;
            end else begin
                din = '0; din_valid = 1'b0;
            end
            @(negedge clk);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (sout !== 1'b0 || sout_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_idle%0d got s=%b v=%b expected 0/0", c, sout, sout_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_midframe_reset();
        bit   ok;
        logic eb, ed;
        wait_ready(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL mid_ready_timeout got 0 expected 1");
            return;
        end
        din = 8'hA5; din_valid = 1'b1;
        push_frame(8'hA5);
        @(negedge clk);
        din_valid = 1'b0; din = '0;
        for (int c = 0; c < 5; c++) begin
            eb = bit_q.pop_front();
            ed = done_q.pop_front();
            checks++;
            if (sout_valid !== 1'b1 || sout !== eb || frame_done !== ed) begin
                errors++;
                $display("[TB] FAIL mid_bit%0d got v=%b s=%b d=%b expected v=1 s=%b d=%b",
                         c, sout_valid, sout, frame_done, eb, ed);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({din_ready, sout, sout_valid, frame_done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_async_clear got %b expected 0000",
                     {din_ready, sout, sout_valid, frame_done});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        bit_q.delete();
        done_q.delete();
        for (int c = 0; c < FL + 2; c++) begin
            @(negedge clk);
            checks++;
            if (sout_valid !== 1'b0 || frame_done !== 1'b0 || din_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mid_after_release%0d got v=%b d=%b r=%b expected 0/0/1",
                         c, sout_valid, frame_done, din_ready);
            end
        end
    endtask

`ifdef BIT_SERIALIZER_PARITY_EN
    task automatic test_parity();
        bit               ok;
        logic             eb, ed;
        logic [WIDTH-1:0] words[2];
        logic             pars[2];
        words[0] = 8'h07; pars[0] = 1'b1;
        words[1] = 8'h03; pars[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_ready(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL parity_ready_timeout got 0 expected 1");
                return;
            end
            din = words[k]; din_valid = 1'b1;
            push_frame(words[k]);
            @(negedge clk);
            din_valid = 1'b0; din = '0;
            for (int c = 0; c < FL; c++) begin
                eb = bit_q.pop_front();
                ed = done_q.pop_front();
                checks++;
                if (sout_valid !== 1'b1 || sout !== eb || frame_done !== ed) begin
                    errors++;
                    $display("[TB] FAIL parity_w%0d_bit%0d got v=%b s=%b d=%b expected v=1 s=%b d=%b",
                             k, c, sout_valid, sout, frame_done, eb, ed);
                end
                if (c == FL - 1) begin
                    checks++;
                    if (sout !== pars[k]) begin
                        errors++;
                        $display("[TB] FAIL parity_w%0d_value got %b expected %b", k, sout, pars[k]);
                    end
                end
                @(negedge clk);
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        din = '0;
        din_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy();
        test_midframe_reset();
`ifdef BIT_SERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
